mem_port_arbiter: RTL and testbench

- Shares one physical memory port between the instruction-side and data-side cache miss paths of the pipelined LC-3 core.
- Sits between the I-cache/D-cache miss interfaces and the single-ported line memory.
- Serializes requests, alternates fairly under contention and routes each response back to its owner.
- Lets the core run against a realistic single-port memory instead of a dual-access ideal one.

---
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one line-wide memory port between the I-cache and
// D-cache miss paths. Requests are serialized through a small FSM; under
// contention the grant alternates using last_grant. Address, write data and
// the write flag are latched on the grant edge so requester-side changes
// during a transfer cannot disturb the memory port.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t                state;
  state_t                next_state;
  logic                  last_grant;   // 0 = I side served last, 1 = D side
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic                  write_q;
  logic                  i_pend;
  logic                  d_pend;
  logic                  grant_i;
  logic                  grant_d;

  assign i_pend = i_read;
  assign d_pend = d_read | d_write;

  // Memory-side data paths come straight from the latched request; read data
  // is passed through and is only meaningful while the matching resp is high.
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign i_rdata      = pmem_rdata;
  assign d_rdata      = pmem_rdata;

  // Next-state, grant decision and strobe/response decode.
  always_comb begin
    next_state = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    case (state)
      IDLE: begin
        if (i_pend && d_pend) begin
          // Contention: favour the side that was not served last.
          if (last_grant) grant_i = 1'b1;
          else            grant_d = 1'b1;
        end else if (d_pend) begin
          grant_d = 1'b1;
        end else if (i_pend) begin
          grant_i = 1'b1;
        end
        if (grant_i)      next_state = SERVE_I;
        else if (grant_d) next_state = SERVE_D;
      end
      SERVE_I: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          i_resp     = 1'b1;
          next_state = IDLE;
        end
      end
      SERVE_D: begin
        // A simultaneous read+write from the D side resolves to the write.
        if (write_q) pmem_write = 1'b1;
        else         pmem_read  = 1'b1;
        if (pmem_resp) begin
          d_resp     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register and fairness memory; reset aborts any transfer at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b0;
    end else begin
      state <= next_state;
      if (grant_i)      last_grant <= 1'b0;
      else if (grant_d) last_grant <= 1'b1;
    end
  end

  // Latch the granted request so the memory port stays stable until resp.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else if (grant_i) begin
      addr_q <= i_address;
    end else if (grant_d) begin
      addr_q  <= d_address;
      wdata_q <= d_wdata;
      write_q <= d_write;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios followed by a randomized phase.
// The bench plays both requesters and a variable-latency memory, and a
// transaction-level reference model predicts grants and memory-port activity.
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_address;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  int checks = 0;
  int failures = 0;

  // memory model
  int            mem_lat, mem_cnt, fixed_lat;
  logic          spurious_en, use_fix;
  logic [LW-1:0] fix_rdata;
  // reference model: one outstanding transaction at most
  logic          m_busy, m_side, m_last, m_wr;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;
  // observations
  logic [AW-1:0] addr_log[$];
  int            cnt_rd, cnt_wr, cnt_iresp, cnt_dresp;
  int            gap_cnt, last_gap, wait_i, wait_d;
  logic          gap_on, in_tx, drop_i, drop_d;

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    cnt_rd = 0; cnt_wr = 0; cnt_iresp = 0; cnt_dresp = 0;
    addr_log.delete();
    last_gap = -1;
  endtask

  // One clock cycle: memory reacts at negedge, outputs are checked, model advances,
  // and requesters drop a completed request just after the edge.
  task automatic tick();
    logic strobe, exp_rd, exp_wr, exp_ir, exp_dr, pi, pd, s, seen_i, seen_d;
    @(negedge clk);
    strobe = pmem_read | pmem_write;
    if (strobe && !rst) begin
      if (mem_cnt == 0) mem_lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
      mem_cnt++;
      if (mem_cnt >= mem_lat) begin
        pmem_resp  = 1'b1;
        pmem_rdata = use_fix ? fix_rdata : rand_line();
        mem_cnt    = 0;
      end else begin
        pmem_resp  = 1'b0;
        pmem_rdata = rand_line();
      end
    end else begin
      pmem_resp  = spurious_en ? 1'($urandom_range(0, 1)) : 1'b0;
      pmem_rdata = rand_line();
    end
    #1;
    exp_rd = 1'b0; exp_wr = 1'b0; exp_ir = 1'b0; exp_dr = 1'b0;
    if (!rst && m_busy) begin
      exp_wr = m_side & m_wr;
      exp_rd = ~exp_wr;
      exp_ir = ~m_side & pmem_resp;
      exp_dr = m_side & pmem_resp;
      chk("pmem_address", LW'(pmem_address), LW'(m_addr));
      if (exp_wr) chk("pmem_wdata", pmem_wdata, m_wdata);
    end
    chk("pmem_read", LW'(pmem_read), LW'(exp_rd));
    chk("pmem_write", LW'(pmem_write), LW'(exp_wr));
    chk("i_resp", LW'(i_resp), LW'(exp_ir));
    chk("d_resp", LW'(d_resp), LW'(exp_dr));
    if (i_resp) chk("i_rdata", i_rdata, pmem_rdata);
    if (d_resp) chk("d_rdata", d_rdata, pmem_rdata);
    if (pmem_read)  cnt_rd++;
    if (pmem_write) cnt_wr++;
    if (i_resp)     cnt_iresp++;
    if (d_resp)     cnt_dresp++;
    if ((pmem_read || pmem_write) && !in_tx) begin
      in_tx = 1'b1;
      addr_log.push_back(pmem_address);
      if (gap_on) begin last_gap = gap_cnt; gap_on = 1'b0; end
    end else if (!(pmem_read || pmem_write) && gap_on) begin
      gap_cnt++;
    end
    seen_i = i_resp;
    seen_d = d_resp;
    if (i_resp || d_resp) begin in_tx = 1'b0; gap_on = 1'b1; gap_cnt = 0; end
    if (!rst) begin
      if (m_busy) begin
        if (pmem_resp) m_busy = 1'b0;
      end else begin
        pi = i_read;
        pd = d_read | d_write;
        if (pi || pd) begin
          s = (pi && pd) ? ~m_last : pd;
          if (s && pi) begin
            wait_i++;
            chk("fair_wait_i", LW'(wait_i <= 1), LW'(1));
          end
          if (!s && pd) begin
            wait_d++;
            chk("fair_wait_d", LW'(wait_d <= 1), LW'(1));
          end
          if (s) wait_d = 0; else wait_i = 0;
          m_busy  = 1'b1;
          m_side  = s;
          m_last  = s;
          m_addr  = s ? d_address : i_address;
          m_wr    = s & d_write;
          m_wdata = d_wdata;
        end
      end
    end
    @(posedge clk);
    #1;
    if (seen_i) i_read = 1'b0;
    if (seen_d) begin d_read = 1'b0; d_write = 1'b0; end
    drop_i = seen_i;
    drop_d = seen_d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pmem_resp = 1'b1;
    #1;
    chk("rst_pmem_read", LW'(pmem_read), LW'(0));
    chk("rst_pmem_write", LW'(pmem_write), LW'(0));
    chk("rst_i_resp", LW'(i_resp), LW'(0));
    chk("rst_d_resp", LW'(d_resp), LW'(0));
    chk("rst_pmem_address", LW'(pmem_address), LW'(0));
    chk("rst_pmem_wdata", pmem_wdata, LW'(0));
    m_busy = 1'b0; m_last = 1'b0; mem_cnt = 0;
    in_tx = 1'b0; gap_on = 1'b0; wait_i = 0; wait_d = 0;
  endtask

  task automatic wait_resps(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while ((cnt_iresp + cnt_dresp) < n && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_done"}, LW'((cnt_iresp + cnt_dresp) >= n), LW'(1));
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((i_read || d_read || d_write || in_tx) && k < 40) begin
      tick();
      k++;
    end
    chk("drain", LW'(i_read || d_read || d_write || in_tx), LW'(0));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    logic          r;
    int            k;
    rst = 1'b1;
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    fixed_lat = 0; spurious_en = 1'b0; use_fix = 1'b0; fix_rdata = '0;
    mem_lat = 1; drop_i = 1'b0; drop_d = 1'b0;
    m_side = 1'b0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
    gap_cnt = 0;
    clear_obs();
    do_reset();
    tick();
    tick();
    rst = 1'b0;

    // I-side read, memory latency 3
    clear_obs();
    fixed_lat = 3; use_fix = 1'b1; fix_rdata = {16{8'hA5}};
    i_read = 1'b1; i_address = 16'h1230;
    wait_resps("t1", 1, 20);
    chk("t1_rdata_seen", LW'(cnt_iresp), LW'(1));
    tick();
    chk("t1_read_cycles", LW'(cnt_rd), LW'(3));
    chk("t1_i_resp_count", LW'(cnt_iresp), LW'(1));
    chk("t1_d_resp_count", LW'(cnt_dresp), LW'(0));
    chk("t1_addr", LW'(addr_log[0]), LW'(16'h1230));
    use_fix = 1'b0;

    // D-side writeback, memory latency 1
    clear_obs();
    fixed_lat = 1;
    d_write = 1'b1; d_address = 16'h4000; d_wdata = 128'h00112233445566778899AABBCCDDEEFF;
    wait_resps("t2", 1, 20);
    tick();
    chk("t2_write_cycles", LW'(cnt_wr), LW'(1));
    chk("t2_read_cycles", LW'(cnt_rd), LW'(0));
    chk("t2_d_resp_count", LW'(cnt_dresp), LW'(1));
    chk("t2_addr", LW'(addr_log[0]), LW'(16'h4000));

    // Both sides requesting out of reset: D first, one idle cycle between
    i_read = 1'b1; i_address = 16'h0100;
    d_read = 1'b1; d_address = 16'h2000;
    do_reset();
    tick();
    rst = 1'b0;
    clear_obs();
    fixed_lat = 2;
    wait_resps("t3", 2, 40);
    drain();
    chk("t3_count", LW'(addr_log.size()), LW'(2));
    chk("t3_first", LW'(addr_log[0]), LW'(16'h2000));
    chk("t3_second", LW'(addr_log[1]), LW'(16'h0100));
    chk("t3_gap", LW'(last_gap), LW'(1));

    // Continuous contention: grants alternate D,I,D,I,D,I
    clear_obs();
    fixed_lat = 0;
    k = 0;
    i_read = 1'b1; i_address = 16'h1000;
    d_read = 1'b1; d_address = 16'h2000;
    while ((cnt_iresp + cnt_dresp) < 6 && k < 100) begin
      tick();
      k++;
      if (!i_read && !drop_i && (cnt_iresp + cnt_dresp) < 6) begin
        i_read = 1'b1; i_address = 16'h1000 + AW'(k);
      end
      if (!d_read && !drop_d && (cnt_iresp + cnt_dresp) < 6) begin
        d_read = 1'b1; d_address = 16'h2000 + AW'(k);
      end
    end
    chk("t4_done", LW'((cnt_iresp + cnt_dresp) >= 6), LW'(1));
    drain();
    for (int j = 0; j < 6; j++) begin
      a = addr_log[j];
      chk("t4_order", LW'(a[13]), LW'(j % 2 == 0));
    end

    // Request changes during SERVE_I do not leak into the memory port
    clear_obs();
    fixed_lat = 3;
    i_read = 1'b1; i_address = 16'h1230;
    tick();
    tick();
    i_address = 16'h5550;
    d_read = 1'b1; d_address = 16'h3330;
    wait_resps("t5", 2, 40);
    drain();
    chk("t5_first", LW'(addr_log[0]), LW'(16'h1230));
    chk("t5_second", LW'(addr_log[1]), LW'(16'h3330));

    // Reset two cycles into a D read: abort, then D re-granted first
    clear_obs();
    fixed_lat = 10;
    d_read = 1'b1; d_address = 16'h0ABC;
    tick();
    tick();
    tick();
    i_read = 1'b1; i_address = 16'h0777;
    do_reset();
    tick();
    rst = 1'b0;
    fixed_lat = 2;
    wait_resps("t6", 2, 40);
    drain();
    chk("t6_d_resp_count", LW'(cnt_dresp), LW'(1));
    chk("t6_i_resp_count", LW'(cnt_iresp), LW'(1));
    chk("t6_aborted", LW'(addr_log[0]), LW'(16'h0ABC));
    chk("t6_regrant_d", LW'(addr_log[1]), LW'(16'h0ABC));
    chk("t6_then_i", LW'(addr_log[2]), LW'(16'h0777));

    // Randomized traffic with random latency and stray pmem_resp in IDLE
    clear_obs();
    fixed_lat = 0;
    spurious_en = 1'b1;
    for (int c = 0; c < 600; c++) begin
      tick();
      if (!i_read && !drop_i && ($urandom_range(0, 2) == 0)) begin
        i_read = 1'b1; i_address = AW'($urandom);
      end else if (i_read && ($urandom_range(0, 7) == 0)) begin
        i_address = AW'($urandom);
      end
      if (!d_read && !d_write && !drop_d && ($urandom_range(0, 2) == 0)) begin
        r = 1'($urandom_range(0, 1));
        d_write = r; d_read = ~r;
        d_address = AW'($urandom); d_wdata = rand_line();
      end else if ((d_read || d_write) && ($urandom_range(0, 7) == 0)) begin
        d_address = AW'($urandom); d_wdata = rand_line();
      end
    end
    spurious_en = 1'b0;
    drain();
    chk("rand_progress", LW'((cnt_iresp > 0) && (cnt_dresp > 0)), LW'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
